// File: rtl/gate_test_sched.sv
// rtl/gate_test_sched.sv - sequencer that sweeps gate-tester blocks over START/FINISH and latches their error counts
// Optional watchdog on the per-tester wait is enabled with macro GTS_TIMEOUT_EN.
module gate_test_sched #(
  parameter int NUM_GATES   = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 524288
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   RUN_START,
  input  logic [NUM_GATES-1:0]   GATE_MASK,
  output logic                   RUN_BUSY,
  output logic                   RUN_DONE,
  output logic [NUM_GATES-1:0]   GATE_START,
  input  logic [NUM_GATES-1:0]   GATE_FINISH,
  input  logic [NUM_GATES*32-1:0] GATE_ERROR,
  input  logic [IDX_W-1:0]       ERR_SEL,
  output logic [31:0]            ERR_RD,
  output logic [NUM_GATES-1:0]   FAIL_MASK,
  output logic [NUM_GATES-1:0]   TIMEOUT_MASK,
  output logic [31:0]            TOTAL_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_GATES-1:0] pend, pend_nxt;
  logic [IDX_W-1:0]     cur, cur_nxt;
  logic [31:0]          slot   [NUM_GATES];
  logic [31:0]          err_in [NUM_GATES];
  logic                 accept;
  logic                 finish_hit;
  logic                 timeout_hit;
  logic [31:0]          cur_err;
  logic [31:0]          add_val;
  logic [32:0]          sum;

  if (NUM_GATES < 1 || NUM_GATES > 16 ||
      IDX_W != ((NUM_GATES > 1) ? $clog2(NUM_GATES) : 1) ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << 20)) begin : g_bad_params
    $error("gate_test_sched: inconsistent parameters");
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_err
    assign err_in[g] = GATE_ERROR[32*g +: 32];
  end

  assign accept     = (state == S_IDLE) && RUN_START;
  assign finish_hit = (state == S_WAIT) && GATE_FINISH[cur];
  assign cur_err    = err_in[cur];
  // A watchdog expiry records the slot as maximally failing.
  assign add_val    = timeout_hit ? 32'hFFFF_FFFF : cur_err;
  assign sum        = {1'b0, TOTAL_ERR} + {1'b0, add_val};
  assign ERR_RD     = (int'(ERR_SEL) < NUM_GATES) ? slot[ERR_SEL] : 32'd0;

`ifdef GTS_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  logic [19:0]          to_cnt;
  logic [NUM_GATES-1:0] to_mask;

  assign timeout_hit  = (state == S_WAIT) && !GATE_FINISH[cur] && (to_cnt == TO_LAST);
  assign TIMEOUT_MASK = to_mask;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      to_cnt  <= '0;
      to_mask <= '0;
    end else begin
      if (state == S_LAUNCH) begin
        to_cnt <= '0;
      end else if (state == S_WAIT) begin
        to_cnt <= to_cnt + 20'd1;
      end
      if (accept) begin
        to_mask <= '0;
      end else if (timeout_hit) begin
        to_mask[cur] <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign TIMEOUT_MASK = '0;
`endif

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    cur_nxt   = cur;
    case (state)
      S_IDLE: begin
        if (RUN_START) begin
          pend_nxt  = GATE_MASK;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pend == '0) begin
          state_nxt = S_DONE;
        end else begin
          // Descending loop leaves the lowest set bit selected.
          for (int i = NUM_GATES - 1; i >= 0; i--) begin
            if (pend[i]) cur_nxt = IDX_W'(i);
          end
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (finish_hit) begin
          state_nxt = S_DRAIN;
        end else if (timeout_hit) begin
          pend_nxt[cur] = 1'b0;
          state_nxt     = S_SCAN;
        end
      end
      S_DRAIN: begin
        if (!GATE_FINISH[cur]) begin
          pend_nxt[cur] = 1'b0;
          state_nxt     = S_SCAN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      pend  <= '0;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      cur   <= cur_nxt;
    end
  end

  // Outputs are registered off the next state so they line up with the state they belong to.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      RUN_BUSY   <= 1'b0;
      RUN_DONE   <= 1'b0;
      GATE_START <= '0;
      FAIL_MASK  <= '0;
      TOTAL_ERR  <= '0;
      for (int i = 0; i < NUM_GATES; i++) slot[i] <= '0;
    end else begin
      RUN_BUSY   <= (state_nxt != S_IDLE);
      RUN_DONE   <= (state_nxt == S_DONE);
      GATE_START <= '0;
      if (state == S_SCAN && state_nxt == S_LAUNCH) begin
        GATE_START[cur_nxt] <= 1'b1;
      end
      if (accept) begin
        FAIL_MASK <= '0;
        TOTAL_ERR <= '0;
        for (int i = 0; i < NUM_GATES; i++) slot[i] <= '0;
      end else if (finish_hit || timeout_hit) begin
        slot[cur]      <= add_val;
        FAIL_MASK[cur] <= |add_val;
        TOTAL_ERR      <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      end
    end
  end

endmodule

// File: tb/tb_gate_test_sched.sv
// tb/tb_gate_test_sched.sv - directed bench for gate_test_sched with behavioural tester models
module tb_gate_test_sched;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         RUN_START;
  logic [3:0]   GATE_MASK;
  logic         RUN_BUSY;
  logic         RUN_DONE;
  logic [3:0]   GATE_START;
  logic [3:0]   finish;
  logic [127:0] gerr;
  logic [1:0]   ERR_SEL;
  logic [31:0]  ERR_RD;
  logic [3:0]   FAIL_MASK;
  logic [3:0]   TIMEOUT_MASK;
  logic [31:0]  TOTAL_ERR;

  int total = 0;
  int bad   = 0;

  gate_test_sched #(.NUM_GATES(4), .IDX_W(2), .TIMEOUT_CYC(100)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .RUN_START    (RUN_START),
    .GATE_MASK    (GATE_MASK),
    .RUN_BUSY     (RUN_BUSY),
    .RUN_DONE     (RUN_DONE),
    .GATE_START   (GATE_START),
    .GATE_FINISH  (finish),
    .GATE_ERROR   (gerr),
    .ERR_SEL      (ERR_SEL),
    .ERR_RD       (ERR_RD),
    .FAIL_MASK    (FAIL_MASK),
    .TIMEOUT_MASK (TIMEOUT_MASK),
    .TOTAL_ERR    (TOTAL_ERR)
  );

  always #5 sys_clk = ~sys_clk;

  // Tester models: after START, FINISH rises at phase lat, holds for hold cycles, then count clears.
  int          lat  [4];
  int          hold [4];
  int          ph   [4];
  logic [31:0] err_val [4];
  bit          hang [4];

  always @(posedge sys_clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (ph[i] == 0) begin
        if (GATE_START[i] && !hang[i]) ph[i] = 1;
      end else begin
        ph[i]++;
      end
      if (ph[i] != 0 && ph[i] >= lat[i] && ph[i] < lat[i] + hold[i]) begin
        finish[i] = 1'b1;
        gerr[32*i +: 32] = err_val[i];
      end else begin
        finish[i] = 1'b0;
        gerr[32*i +: 32] = 32'd0;
        if (ph[i] >= lat[i] + hold[i]) ph[i] = 0;
      end
    end
  end

  int starts [4];
  int order [$];
  int done_cnt;
  int multi_cnt;
  logic [3:0] gs_prev = 4'd0;

  always @(negedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (GATE_START[i]) starts[i]++;
      if (GATE_START[i] && !gs_prev[i]) order.push_back(i);
    end
    if ($countones(GATE_START) > 1) multi_cnt++;
    if (RUN_DONE) done_cnt++;
    gs_prev = GATE_START;
  end

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) starts[i] = 0;
    order.delete();
    done_cnt  = 0;
    multi_cnt = 0;
  endtask

  task automatic set_tester(input int i, input int l, input int h, input logic [31:0] e, input bit hg);
    lat[i] = l; hold[i] = h; err_val[i] = e; hang[i] = hg;
  endtask

  task automatic start_sweep(input logic [3:0] m);
    @(negedge sys_clk);
    GATE_MASK = m;
    RUN_START = 1'b1;
    @(negedge sys_clk);
    RUN_START = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge sys_clk);
      if (RUN_DONE) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++; if (RUN_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", RUN_BUSY); end
    total++; if (RUN_DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", RUN_DONE); end
    total++; if (GATE_START !== 4'd0) begin bad++; $display("FAIL reset_start got=%b exp=0000", GATE_START); end
    total++; if (FAIL_MASK !== 4'd0) begin bad++; $display("FAIL reset_fail got=%b exp=0000", FAIL_MASK); end
    total++; if (TIMEOUT_MASK !== 4'd0) begin bad++; $display("FAIL reset_tmo got=%b exp=0000", TIMEOUT_MASK); end
    total++; if (TOTAL_ERR !== 32'd0) begin bad++; $display("FAIL reset_total got=%h exp=0", TOTAL_ERR); end
    for (int s = 0; s < 4; s++) begin
      ERR_SEL = 2'(s); #1;
      total++; if (ERR_RD !== 32'd0) begin bad++; $display("FAIL reset_slot%0d got=%h exp=0", s, ERR_RD); end
    end
  endtask

  task automatic test_basic();
    int cyc = 0, f1_rise = 0, f1_fall = 0, s3 = 0;
    logic [31:0] tot_at_rise = 32'hDEAD, tot_after = 32'hDEAD;
    bit seen = 1'b0;
    clear_logs();
    set_tester(0, 3, 2, 32'd0, 0);
    set_tester(1, 4, 3, 32'd5, 0);
    set_tester(2, 3, 2, 32'd9, 0);
    set_tester(3, 2, 2, 32'd7, 0);
    start_sweep(4'b1011);
    total++; if (RUN_BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy_t1 got=%b exp=1", RUN_BUSY); end
    total++; if (GATE_START !== 4'd0) begin bad++; $display("FAIL basic_start_t1 got=%b exp=0000", GATE_START); end
    @(negedge sys_clk);
    total++; if (GATE_START !== 4'b0001) begin bad++; $display("FAIL basic_start_t2 got=%b exp=0001", GATE_START); end
    for (int k = 0; k < 300; k++) begin
      cyc++;
      if (finish[1] && f1_rise == 0) begin f1_rise = cyc; tot_at_rise = TOTAL_ERR; end
      if (f1_rise != 0 && cyc == f1_rise + 1) tot_after = TOTAL_ERR;
      if (f1_rise != 0 && !finish[1] && f1_fall == 0) f1_fall = cyc;
      if (GATE_START[3] && s3 == 0) s3 = cyc;
      if (RUN_DONE) begin seen = 1'b1; break; end
      @(negedge sys_clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    total++; if (tot_at_rise !== 32'd0) begin bad++; $display("FAIL basic_total_pre got=%h exp=0", tot_at_rise); end
    total++; if (tot_after !== 32'd5) begin bad++; $display("FAIL basic_total_post got=%h exp=5", tot_after); end
    total++; if (s3 - f1_fall != 2) begin bad++; $display("FAIL basic_gap got=%0d exp=2", s3 - f1_fall); end
    repeat (3) @(negedge sys_clk);
    total++; if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 3) begin
      bad++; $display("FAIL basic_order got=%p exp=0,1,3", order);
    end
    total++; if (starts[0] != 1 || starts[1] != 1 || starts[2] != 0 || starts[3] != 1) begin
      bad++; $display("FAIL basic_starts got=%0d%0d%0d%0d exp=1101", starts[0], starts[1], starts[2], starts[3]);
    end
    total++; if (multi_cnt != 0) begin bad++; $display("FAIL basic_onehot got=%0d exp=0", multi_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (RUN_BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", RUN_BUSY); end
    total++; if (FAIL_MASK !== 4'b1010) begin bad++; $display("FAIL basic_fail got=%b exp=1010", FAIL_MASK); end
    total++; if (TIMEOUT_MASK !== 4'b0000) begin bad++; $display("FAIL basic_tmo got=%b exp=0000", TIMEOUT_MASK); end
    total++; if (TOTAL_ERR !== 32'd12) begin bad++; $display("FAIL basic_total got=%h exp=c", TOTAL_ERR); end
    ERR_SEL = 2'd3; #1;
    total++; if (ERR_RD !== 32'd7) begin bad++; $display("FAIL basic_slot3 got=%h exp=7", ERR_RD); end
    ERR_SEL = 2'd1; #1;
    total++; if (ERR_RD !== 32'd5) begin bad++; $display("FAIL basic_slot1 got=%h exp=5", ERR_RD); end
    ERR_SEL = 2'd2; #1;
    total++; if (ERR_RD !== 32'd0) begin bad++; $display("FAIL basic_slot2 got=%h exp=0", ERR_RD); end
  endtask

  task automatic test_empty();
    clear_logs();
    start_sweep(4'b0000);
    total++; if (RUN_BUSY !== 1'b1 || RUN_DONE !== 1'b0) begin bad++; $display("FAIL empty_k1 got=%b%b exp=10", RUN_BUSY, RUN_DONE); end
    total++; if (TOTAL_ERR !== 32'd0) begin bad++; $display("FAIL empty_total_clr got=%h exp=0", TOTAL_ERR); end
    @(negedge sys_clk);
    total++; if (RUN_BUSY !== 1'b1 || RUN_DONE !== 1'b1) begin bad++; $display("FAIL empty_k2 got=%b%b exp=11", RUN_BUSY, RUN_DONE); end
    @(negedge sys_clk);
    total++; if (RUN_BUSY !== 1'b0 || RUN_DONE !== 1'b0) begin bad++; $display("FAIL empty_k3 got=%b%b exp=00", RUN_BUSY, RUN_DONE); end
    repeat (2) @(negedge sys_clk);
    total++; if (starts[0] + starts[1] + starts[2] + starts[3] != 0) begin bad++; $display("FAIL empty_starts got=%0d exp=0", starts[0] + starts[1] + starts[2] + starts[3]); end
    total++; if (FAIL_MASK !== 4'd0) begin bad++; $display("FAIL empty_fail got=%b exp=0000", FAIL_MASK); end
    ERR_SEL = 2'd3; #1;
    total++; if (ERR_RD !== 32'd0) begin bad++; $display("FAIL empty_slot3 got=%h exp=0", ERR_RD); end
  endtask

  task automatic test_saturate();
    bit seen;
    clear_logs();
    set_tester(0, 3, 2, 32'hFFFF_FFF0, 0);
    set_tester(1, 3, 2, 32'h0000_0020, 0);
    start_sweep(4'b0011);
    wait_done(200, seen);
    total++; if (!seen) begin bad++; $display("FAIL sat_done_timeout got=0 exp=1"); end
    @(negedge sys_clk);
    total++; if (TOTAL_ERR !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_total got=%h exp=ffffffff", TOTAL_ERR); end
    total++; if (FAIL_MASK !== 4'b0011) begin bad++; $display("FAIL sat_fail got=%b exp=0011", FAIL_MASK); end
    ERR_SEL = 2'd0; #1;
    total++; if (ERR_RD !== 32'hFFFF_FFF0) begin bad++; $display("FAIL sat_slot0 got=%h exp=fffffff0", ERR_RD); end
    ERR_SEL = 2'd1; #1;
    total++; if (ERR_RD !== 32'h20) begin bad++; $display("FAIL sat_slot1 got=%h exp=20", ERR_RD); end
  endtask

  task automatic test_busy_reset();
    bit seen;
    bit started = 1'b0;
    clear_logs();
    set_tester(0, 6, 2, 32'd1, 0);
    set_tester(1, 6, 2, 32'd2, 0);
    start_sweep(4'b0011);
    repeat (3) @(negedge sys_clk);
    GATE_MASK = 4'b1111;
    RUN_START = 1'b1;
    @(negedge sys_clk);
    RUN_START = 1'b0;
    total++; if (RUN_BUSY !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", RUN_BUSY); end
    wait_done(200, seen);
    total++; if (!seen) begin bad++; $display("FAIL ign_done_timeout got=0 exp=1"); end
    repeat (4) @(negedge sys_clk);
    total++; if (starts[0] != 1 || starts[1] != 1 || starts[2] != 0 || starts[3] != 0) begin
      bad++; $display("FAIL ign_starts got=%0d%0d%0d%0d exp=1100", starts[0], starts[1], starts[2], starts[3]);
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (TOTAL_ERR !== 32'd3) begin bad++; $display("FAIL ign_total got=%h exp=3", TOTAL_ERR); end

    clear_logs();
    set_tester(0, 20, 2, 32'd9, 0);
    start_sweep(4'b0001);
    for (int k = 0; k < 10; k++) begin
      if (GATE_START[0]) begin started = 1'b1; break; end
      @(negedge sys_clk);
    end
    total++; if (!started) begin bad++; $display("FAIL rst_launch_timeout got=0 exp=1"); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    total++; if (RUN_BUSY !== 1'b0 || RUN_DONE !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b exp=00", RUN_BUSY, RUN_DONE); end
    total++; if (GATE_START !== 4'd0) begin bad++; $display("FAIL rst_start got=%b exp=0000", GATE_START); end
    total++; if (FAIL_MASK !== 4'd0 || TOTAL_ERR !== 32'd0) begin bad++; $display("FAIL rst_results got=%b/%h exp=0000/0", FAIL_MASK, TOTAL_ERR); end
    repeat (30) @(negedge sys_clk);
    total++; if (starts[0] != 1 || done_cnt != 0) begin bad++; $display("FAIL rst_idle got=%0d/%0d exp=1/0", starts[0], done_cnt); end
    total++; if (TOTAL_ERR !== 32'd0 || RUN_BUSY !== 1'b0) begin bad++; $display("FAIL rst_unobserved got=%h/%b exp=0/0", TOTAL_ERR, RUN_BUSY); end

    clear_logs();
    set_tester(0, 3, 2, 32'd9, 0);
    start_sweep(4'b0001);
    wait_done(200, seen);
    total++; if (!seen) begin bad++; $display("FAIL rerun_done_timeout got=0 exp=1"); end
    repeat (2) @(negedge sys_clk);
    total++; if (TOTAL_ERR !== 32'd9 || FAIL_MASK !== 4'b0001) begin bad++; $display("FAIL rerun_results got=%h/%b exp=9/0001", TOTAL_ERR, FAIL_MASK); end
    ERR_SEL = 2'd0; #1;
    total++; if (ERR_RD !== 32'd9) begin bad++; $display("FAIL rerun_slot0 got=%h exp=9", ERR_RD); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rerun_done_cnt got=%0d exp=1", done_cnt); end
  endtask

`ifdef GTS_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    clear_logs();
    set_tester(1, 3, 2, 32'd4, 0);
    set_tester(2, 3, 2, 32'd1, 1);
    start_sweep(4'b0110);
    wait_done(400, seen);
    total++; if (!seen) begin bad++; $display("FAIL tmo_done_timeout got=0 exp=1"); end
    @(negedge sys_clk);
    total++; if (TIMEOUT_MASK !== 4'b0100) begin bad++; $display("FAIL tmo_mask got=%b exp=0100", TIMEOUT_MASK); end
    total++; if (FAIL_MASK !== 4'b0110) begin bad++; $display("FAIL tmo_fail got=%b exp=0110", FAIL_MASK); end
    total++; if (TOTAL_ERR !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmo_total got=%h exp=ffffffff", TOTAL_ERR); end
    ERR_SEL = 2'd2; #1;
    total++; if (ERR_RD !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmo_slot2 got=%h exp=ffffffff", ERR_RD); end
    ERR_SEL = 2'd1; #1;
    total++; if (ERR_RD !== 32'd4) begin bad++; $display("FAIL tmo_slot1 got=%h exp=4", ERR_RD); end
  endtask
`endif

  initial begin
    sys_rst   = 1'b1;
    RUN_START = 1'b0;
    GATE_MASK = 4'd0;
    ERR_SEL   = 2'd0;
    finish    = 4'd0;
    gerr      = '0;
    for (int i = 0; i < 4; i++) begin
      ph[i] = 0;
      set_tester(i, 3, 2, 32'd0, 0);
    end
    clear_logs();
    test_reset();
    test_basic();
    test_empty();
    test_saturate();
    test_busy_reset();
`ifdef GTS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_test_sched.md
# gate_test_sched

Sequencer that runs a bank of gate-tester blocks one at a time over their START/FINISH handshake. It latches each tester's 32-bit error count, flags failing and hung testers, and reports a saturating total. It sits between the host/UART control logic and the per-gate testers, so the host issues one sweep command instead of driving every tester.

## Interface
- NUM_GATES, 4, number of tester slots (1..16)
- IDX_W, 2, width of ERR_SEL; must equal clog2(NUM_GATES), min 1
- TIMEOUT_CYC, 524288, max cycles to wait for a tester's FINISH (only with GTS_TIMEOUT_EN)

Ports:
- sys_clk  in  1  single clock; everything is on the rising edge
- sys_rst  in  1  one clock; reset is synchronous and active-high
- RUN_START  in  1  sweep request; sampled only in IDLE
- GATE_MASK  in  NUM_GATES  testers to run; captured when RUN_START is accepted
- RUN_BUSY  out  1  high from acceptance until the cycle RUN_DONE is high (inclusive)
- RUN_DONE  out  1  one-cycle pulse at end of sweep
- GATE_START  out  NUM_GATES  one-hot start pulse to tester i
- GATE_FINISH  in  NUM_GATES  FINISH level from tester i
- GATE_ERROR  in  NUM_GATES*32  flattened error counts; tester i at [32*i+31:32*i]
- ERR_SEL  in  IDX_W  slot select for ERR_RD
- ERR_RD  out  32  latched count of slot ERR_SEL (combinational mux of registers)
- FAIL_MASK  out  NUM_GATES  bit i set if slot i count is non-zero or timed out
- TIMEOUT_MASK  out  NUM_GATES  bit i set if slot i timed out
- TOTAL_ERR  out  32  saturating sum of latched counts

## Operation
- States: IDLE, SCAN, LAUNCH, WAIT, DRAIN, DONE.
- IDLE, RUN_START=1:
  - capture GATE_MASK into pend.
  - clear all latched counts, FAIL_MASK, TIMEOUT_MASK and TOTAL_ERR.
  - go to SCAN.
- SCAN: if pend==0, go to DONE. Otherwise set cur to the lowest set bit of pend and go to LAUNCH.
- LAUNCH: GATE_START[cur]=1 for this cycle only. Clear the timeout counter. Go to WAIT.
- WAIT: on the first cycle with GATE_FINISH[cur]=1:
  - latch GATE_ERROR slice cur into slot cur.
  - add it to TOTAL_ERR, saturating at 0xFFFF_FFFF.
  - set FAIL_MASK[cur] if the count is non-zero.
  - go to DRAIN.
- DRAIN: wait for GATE_FINISH[cur]=0, meaning the tester is back in idle and has cleared its count. Then clear pend[cur] and go to SCAN.
- DONE: RUN_DONE=1 for one cycle, then IDLE.
- The count must be latched on the first FINISH cycle, because the tester zeroes it once it returns to idle.
- RUN_START while busy: ignored, with no queueing.
- GATE_FINISH of a non-current slot: ignored.
- FINISH already high at LAUNCH: treated as completion on the first WAIT cycle.
- Latched results hold after DONE until the next accepted RUN_START.
- Reset mid-sweep:
  - all state and outputs return to reset values and GATE_START is low.
  - the in-flight tester is not aborted; it runs to completion unobserved.

## Timing
- Reset values: RUN_BUSY=0, RUN_DONE=0, GATE_START=0, FAIL_MASK=0, TIMEOUT_MASK=0, TOTAL_ERR=0, all slots 0, state IDLE.
- All outputs except ERR_RD are registered.
- RUN_START sampled at edge t: RUN_BUSY=1 from t+1, SCAN during t+1, first GATE_START pulse during t+2.
- FINISH seen at edge f: slot, TOTAL_ERR and FAIL_MASK update at f+1.
- Gate-to-gate overhead: minimum 2 cycles after FINISH falls, then the next GATE_START.
- Empty mask: RUN_DONE pulses 2 cycles after acceptance; no GATE_START ever asserts.

## Configuration
- Macro GTS_TIMEOUT_EN enables the WAIT watchdog.
- With GTS_TIMEOUT_EN: a 20-bit counter increments in WAIT. When it reaches TIMEOUT_CYC-1 without FINISH:
  - slot count = 0xFFFF_FFFF.
  - TIMEOUT_MASK[cur]=1 and FAIL_MASK[cur]=1.
  - TOTAL_ERR saturates.
  - pend[cur] is cleared and the FSM goes straight to SCAN, skipping DRAIN.
- Without GTS_TIMEOUT_EN: WAIT blocks indefinitely, TIMEOUT_MASK is tied to 0, and the counter is not built.

## Test plan
- Mask 4'b1011, models finish with errors 0, 5, -, 7 → GATE_START pulses slots 0, 1, 3 in order, one cycle each; slot 2 never starts; FAIL_MASK=4'b1010; TOTAL_ERR=12; one RUN_DONE; ERR_RD with ERR_SEL=3 returns 7.
- Mask 0 → RUN_DONE 2 cycles after RUN_START, GATE_START stays 0, all results 0.
- Slot 0 count 0xFFFF_FFF0, slot 1 count 0x20 → TOTAL_ERR=0xFFFF_FFFF (saturated), FAIL_MASK=4'b0011.
- GTS_TIMEOUT_EN, TIMEOUT_CYC=100, slot 2 never finishes, mask 4'b0110 → slot 2 = 0xFFFF_FFFF, TIMEOUT_MASK=4'b0100; slot 1 still recorded; RUN_DONE asserts.
- RUN_START re-pulsed mid-sweep, then sys_rst for 1 cycle during WAIT → re-pulse ignored; after reset all outputs are 0 and state is IDLE; a new sweep runs normally.
